// File: rtl/fwd_round_tf.sv
// Forward AES round without key addition: SubBytes (tower-field S-box), ShiftRows, optional MixColumns.
// Define FWD_ROUND_TF_PARALLEL_SBOX_EN for 16 S-boxes and one SUB cycle; the default build uses 4 shared S-boxes.
module fwd_round_tf (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] s_i,
    input  logic         bypass_mc_i,
    output logic [127:0] s_o,
    output logic         done_o,
    output logic         busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] MIX  = 2'd2;

    // GF(16) = GF(2)[x]/(x^4+x+1); GF(256) = GF(16)[y]/(y^2+y+LAMBDA), trace(LAMBDA)=1 so irreducible
    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? x : 8'h00);
            x   = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] x;
        acc = 4'h0;
        x   = a;
        for (int i = 0; i < 4; i++) begin
            acc = acc ^ (b[i] ? x : 4'h0);
            x   = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    // d^14 = d^-1 for d != 0, and 0 maps to 0
    function automatic logic [3:0] gf4_inv(input logic [3:0] d);
        logic [3:0] d2;
        logic [3:0] d4;
        logic [3:0] d8;
        d2 = gf4_mul(d, d);
        d4 = gf4_mul(d2, d2);
        d8 = gf4_mul(d4, d4);
        return gf4_mul(gf4_mul(d2, d4), d8);
    endfunction

    // Column j of m (8 bits at [8j+7:8j]) is the image of input bit j
    function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 8; j++) begin
            r = r ^ (x[j] ? m[8*j +: 8] : 8'h00);
        end
        return r;
    endfunction

    // Isomorphism basis is derived at elaboration: alpha is a root of x^4+x+1 and beta of y^2+y+lambda
    function automatic logic [7:0] find_alpha();
        logic [7:0] r;
        logic [7:0] c;
        logic [7:0] c2;
        r = 8'h00;
        for (int i = 2; i < 256; i++) begin
            c  = 8'(i);
            c2 = gf8_mul(c, c);
            if ((r == 8'h00) && ((gf8_mul(c2, c2) ^ c ^ 8'h01) == 8'h00)) r = c;
        end
        return r;
    endfunction

    function automatic logic [7:0] embed4(input logic [3:0] k, input logic [7:0] alpha);
        logic [7:0] r;
        logic [7:0] pw;
        r  = 8'h00;
        pw = 8'h01;
        for (int i = 0; i < 4; i++) begin
            r  = r ^ (k[i] ? pw : 8'h00);
            pw = gf8_mul(pw, alpha);
        end
        return r;
    endfunction

    function automatic logic [7:0] find_beta(input logic [7:0] lam);
        logic [7:0] r;
        logic [7:0] c;
        r = 8'h00;
        for (int i = 2; i < 256; i++) begin
            c = 8'(i);
            if ((r == 8'h00) && ((gf8_mul(c, c) ^ c ^ lam) == 8'h00)) r = c;
        end
        return r;
    endfunction

    function automatic logic [63:0] build_to_aes(input logic [7:0] alpha, input logic [7:0] beta);
        logic [63:0] m;
        logic [7:0]  pw;
        m  = 64'h0;
        pw = 8'h01;
        for (int j = 0; j < 4; j++) begin
            m[8*j +: 8]     = pw;
            m[8*(j+4) +: 8] = gf8_mul(pw, beta);
            pw              = gf8_mul(pw, alpha);
        end
        return m;
    endfunction

    function automatic logic [63:0] build_to_twr(input logic [63:0] to_aes);
        logic [63:0] m;
        logic [7:0]  img;
        m = 64'h0;
        for (int i = 1; i < 256; i++) begin
            img = lin_map(to_aes, 8'(i));
            for (int b = 0; b < 8; b++) begin
                if (img == (8'h01 << b)) m[8*b +: 8] = 8'(i);
            end
        end
        return m;
    endfunction

    localparam logic [7:0]  ALPHA  = find_alpha();
    localparam logic [7:0]  BETA   = find_beta(embed4(LAMBDA, ALPHA));
    localparam logic [63:0] TO_AES = build_to_aes(ALPHA, BETA);
    localparam logic [63:0] TO_TWR = build_to_twr(TO_AES);

    // (hY+l)^-1 = (h*dinv)Y + (h^l)*dinv with norm d = h^2*lambda + h*l + l^2
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        logic [3:0] h;
        logic [3:0] l;
        logic [3:0] di;
        t   = lin_map(TO_TWR, x);
        h   = t[7:4];
        l   = t[3:0];
        di  = gf4_inv(gf4_mul(gf4_mul(h, h), LAMBDA) ^ gf4_mul(h, l) ^ gf4_mul(l, l));
        inv = lin_map(TO_AES, {gf4_mul(h, di), gf4_mul(h ^ l, di)});
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    logic [1:0]   state_q,  state_d;
    logic [1:0]   cnt_q,    cnt_d;
    logic [127:0] st_q,     st_d;
    logic         bypass_q, bypass_d;
    logic [127:0] s_o_q,    s_o_d;
    logic         done_q,   done_d;
    logic         busy_q,   busy_d;
    logic [127:0] sub_s;
    logic [127:0] sr_s;
    logic [127:0] round_s;

`ifdef FWD_ROUND_TF_PARALLEL_SBOX_EN
    // Substitute all sixteen bytes at once
    always_comb begin
        sub_s = 128'h0;
        for (int k = 0; k < 16; k++) begin
            sub_s[127 - 8*k -: 8] = sbox(st_q[127 - 8*k -: 8]);
        end
    end
`else
    logic [31:0] col_in_s;
    logic [31:0] col_out_s;

    // Substitute the column selected by the counter through four shared S-boxes
    always_comb begin
        case (cnt_q)
            2'd0:    col_in_s = st_q[127:96];
            2'd1:    col_in_s = st_q[95:64];
            2'd2:    col_in_s = st_q[63:32];
            2'd3:    col_in_s = st_q[31:0];
            default: col_in_s = 32'h0;
        endcase
        col_out_s = {sbox(col_in_s[31:24]), sbox(col_in_s[23:16]),
                     sbox(col_in_s[15:8]),  sbox(col_in_s[7:0])};
        sub_s = st_q;
        case (cnt_q)
            2'd0:    sub_s[127:96] = col_out_s;
            2'd1:    sub_s[95:64]  = col_out_s;
            2'd2:    sub_s[63:32]  = col_out_s;
            2'd3:    sub_s[31:0]   = col_out_s;
            default: sub_s         = st_q;
        endcase
    end
`endif

    // ShiftRows then MixColumns unless the final-round bypass was latched
    always_comb begin
        sr_s = shift_rows(st_q);
        if (bypass_q) begin
            round_s = sr_s;
        end else begin
            round_s = {mix_col(sr_s[127:96]), mix_col(sr_s[95:64]),
                       mix_col(sr_s[63:32]),  mix_col(sr_s[31:0])};
        end
    end

    // Round sequencer: IDLE -> SUB -> MIX -> IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        st_d     = st_q;
        bypass_d = bypass_q;
        s_o_d    = s_o_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    st_d     = s_i;
                    bypass_d = bypass_mc_i;
                    cnt_d    = 2'd0;
                    state_d  = SUB;
                end else begin
                    state_d  = IDLE;
                end
            end
            SUB: begin
                st_d = sub_s;
`ifdef FWD_ROUND_TF_PARALLEL_SBOX_EN
                state_d = MIX;
`else
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = MIX;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = SUB;
                end
`endif
            end
            MIX: begin
                s_o_d   = round_s;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 2'd0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            st_q     <= 128'h0;
            bypass_q <= 1'b0;
            s_o_q    <= 128'h0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
            bypass_q <= bypass_d;
            s_o_q    <= s_o_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign s_o    = s_o_q;
    assign done_o = done_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_fwd_round_tf.sv
// Self-checking bench for fwd_round_tf: FIPS-197 vectors plus random rounds against a brute-force AES model.
module tb_fwd_round_tf;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] s_i;
    logic         bypass_mc_i;
    logic [127:0] s_o;
    logic         done_o;
    logic         busy_o;

`ifdef FWD_ROUND_TF_PARALLEL_SBOX_EN
    localparam int LAT        = 2;
    localparam int ABORT_EDGE = 1;
`else
    localparam int LAT        = 5;
    localparam int ABORT_EDGE = 3;
`endif

    int         pass_cnt  = 0;
    int         check_cnt = 0;
    logic [7:0] sbox_tab [0:255];

    fwd_round_tf dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .s_i         (s_i),
        .bypass_mc_i (bypass_mc_i),
        .s_o         (s_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box from first principles: brute-force inverse then the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_tab[a] = s;
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic byp);
        logic [7:0]   st [16];
        logic [7:0]   t  [16];
        logic [7:0]   o  [16];
        logic [127:0] r;
        for (int k = 0; k < 16; k++) st[k] = sbox_tab[s[127 - 8*k -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4*c + rr] = st[4*((c + rr) % 4) + rr];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                o[4*c + rr] = byp ? t[4*c + rr] :
                              (ref_mul(8'h02, t[4*c + rr]) ^ ref_mul(8'h03, t[4*c + (rr+1)%4]) ^
                               t[4*c + (rr+2)%4] ^ t[4*c + (rr+3)%4]);
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = o[k];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one start pulse; inputs are scrambled right after the start edge
    task automatic start_round(input logic [127:0] s, input logic byp);
        @(negedge clk);
        start_i     = 1'b1;
        s_i         = s;
        bypass_mc_i = byp;
        @(negedge clk);
        start_i     = 1'b0;
        s_i         = rand128();
        bypass_mc_i = ~byp;
    endtask

    // Edges from the start edge to done_o, or -1 if it never comes
    task automatic wait_done(output int edges);
        bit found;
        found = 1'b0;
        edges = -1;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                found = 1'b1;
                edges = i;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start_i = 1'b1; s_i = rand128(); bypass_mc_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_cnt++;
        if (s_o !== 128'h0) $display("FAIL reset_s_o: got %h want 0", s_o); else pass_cnt++;
        check_cnt++;
        if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else pass_cnt++;
        check_cnt++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy_with_start: got %b want 0", busy_o); else pass_cnt++;
        rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (busy_o !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy_o); else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [127:0] vin  [4];
        logic         vbyp [4];
        logic [127:0] vexp [4];
        int           edges;
        vin[0] = 128'h0;                                 vbyp[0] = 1'b0;
        vexp[0] = 128'h63636363636363636363636363636363;
        vin[1] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; vbyp[1] = 1'b0;
        vexp[1] = 128'h046681e5e0cb199a48f8d37a2806264c;
        vin[2] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; vbyp[2] = 1'b1;
        vexp[2] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vin[3] = 128'h00112233445566778899aabbccddeeff; vbyp[3] = 1'b1;
        vexp[3] = 128'h63fcac161bee28c3c4c193f54b8233ea;
        for (int v = 0; v < 4; v++) begin
            start_round(vin[v], vbyp[v]);
            check_cnt++;
            if (busy_o !== 1'b1) $display("FAIL vec%0d_busy: got %b want 1", v, busy_o); else pass_cnt++;
            wait_done(edges);
            check_cnt++;
            if (edges != LAT) $display("FAIL vec%0d_latency: got %0d want %0d", v, edges, LAT); else pass_cnt++;
            check_cnt++;
            if (s_o !== vexp[v]) $display("FAIL vec%0d_result: got %h want %h", v, s_o, vexp[v]); else pass_cnt++;
            @(negedge clk);
            check_cnt++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || s_o !== vexp[v])
                $display("FAIL vec%0d_after_done: done=%b busy=%b s_o=%h want 0/0/%h", v, done_o, busy_o, s_o, vexp[v]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [127:0] s;
        logic         b;
        logic [127:0] exp_v;
        int           edges;
        for (int n = 0; n < 16; n++) begin
            s = rand128();
            b = 1'($urandom_range(0, 1));
            exp_v = ref_round(s, b);
            start_round(s, b);
            wait_done(edges);
            check_cnt++;
            if (edges != LAT || s_o !== exp_v)
                $display("FAIL rand%0d: got lat=%0d s_o=%h want lat=%0d s_o=%h", n, edges, s_o, LAT, exp_v);
            else pass_cnt++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [127:0] a;
        logic [127:0] exp_v;
        int           pulses;
        a = rand128();
        exp_v = ref_round(a, 1'b0);
        start_round(a, 1'b0);
        @(negedge clk);
        start_i = 1'b1; s_i = rand128(); bypass_mc_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (done_o === 1'b1) begin
                pulses++;
                check_cnt++;
                if (s_o !== exp_v) $display("FAIL ignore_result: got %h want %h", s_o, exp_v); else pass_cnt++;
            end
            @(negedge clk);
        end
        check_cnt++;
        if (pulses != 1) $display("FAIL ignore_pulses: got %0d want 1", pulses); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        int           edges;
        a = rand128();
        b = rand128();
        start_round(a, 1'b1);
        wait_done(edges);
        check_cnt++;
        if (edges != LAT || s_o !== ref_round(a, 1'b1))
            $display("FAIL b2b_first: got lat=%0d s_o=%h want lat=%0d s_o=%h", edges, s_o, LAT, ref_round(a, 1'b1));
        else pass_cnt++;
        start_i = 1'b1; s_i = b; bypass_mc_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; s_i = rand128();
        check_cnt++;
        if (busy_o !== 1'b1) $display("FAIL b2b_accept: busy got %b want 1", busy_o); else pass_cnt++;
        wait_done(edges);
        check_cnt++;
        if (edges != LAT || s_o !== ref_round(b, 1'b0))
            $display("FAIL b2b_second: got lat=%0d s_o=%h want lat=%0d s_o=%h", edges, s_o, LAT, ref_round(b, 1'b0));
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [127:0] a;
        int           pulses;
        int           edges;
        a = rand128();
        start_round(a, 1'b0);
        repeat (ABORT_EDGE - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cnt++;
        if (s_o !== 128'h0 || busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL abort_state: s_o=%h busy=%b done=%b want 0/0/0", s_o, busy_o, done_o);
        else pass_cnt++;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) pulses++;
        end
        check_cnt++;
        if (pulses != 0) $display("FAIL abort_no_done: got %0d pulses want 0", pulses); else pass_cnt++;
        a = rand128();
        start_round(a, 1'b0);
        wait_done(edges);
        check_cnt++;
        if (edges != LAT || s_o !== ref_round(a, 1'b0))
            $display("FAIL abort_recover: got lat=%0d s_o=%h want lat=%0d s_o=%h", edges, s_o, LAT, ref_round(a, 1'b0));
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; s_i = 128'h0; bypass_mc_i = 1'b0;
        build_sbox();
        test_reset();
        test_vectors();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/fwd_round_tf.md
FWD_ROUND_TF -- requirements
Module: fwd_round_tf

Interface
REQ-001 The block SHALL be parameterless; all variation is through the macro in Configuration.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start_i  input  1  request to process one forward AES round on s_i.
REQ-005 s_i  input  128  input state; bits [127:120] = byte 0; column-major (byte 4c+r = row r, column c).
REQ-006 bypass_mc_i  input  1  1 = skip MixColumns (final round); sampled with start_i.
REQ-007 s_o  output  128  round result; same byte ordering as s_i.
REQ-008 done_o  output  1  one-cycle pulse; s_o is valid in that cycle.
REQ-009 busy_o  output  1  high while a round is in progress.

Function
REQ-010 Operation SHALL be SubBytes, then ShiftRows, then MixColumns (unless bypassed): the forward counterpart of inv_round_tf.
REQ-011 SubBytes SHALL use a composite (tower) field GF((2^4)^2) inverse plus the affine map, bit-exact to the FIPS-197 S-box.
REQ-012 FSM states SHALL be IDLE, SUB, MIX; reset state is IDLE.
REQ-013 IDLE: start_i=1 at an edge latches s_i and bypass_mc_i, clears column counter, and enters SUB.
REQ-014 SUB: 4 shared S-box instances substitute one column per cycle; columns 0..3 in order on 4 consecutive edges; counter value 3 moves to MIX.
REQ-015 MIX: one edge applies ShiftRows (row r rotated left by r) and MixColumns ({02,03,01,01} circulant) or bypass, writes s_o, sets done_o=1, and returns to IDLE.
REQ-016 Latency SHALL be 5 edges after the start edge; done_o is high for exactly one cycle.
REQ-017 busy_o SHALL be 1 in SUB and MIX and 0 in IDLE.
REQ-018 start_i while busy_o=1 SHALL be ignored; it is not queued.
REQ-019 start_i in the same cycle as done_o=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-020 s_o SHALL hold its value until the next done_o; changes to s_i after the start edge SHALL not affect the result.
REQ-021 All GF(2^8) arithmetic SHALL be modulo x^8+x^4+x^3+x+1; the inverse of 00 is 00.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, counter 0, s_o=0, done_o=0 and busy_o=0, including mid-operation.
REQ-023 An aborted round SHALL never produce done_o.
REQ-024 rst has priority over start_i in the same cycle.

Configuration
REQ-025 Macro FWD_ROUND_TF_PARALLEL_SBOX_EN SHALL select the S-box organisation.
REQ-026 When defined: 16 S-box instances; SUB lasts one edge; latency is 2 edges after the start edge.
REQ-027 When undefined: 4 shared S-box instances; latency is 5 edges, as in REQ-016.
REQ-028 The interface and results SHALL be identical in both builds.

Verification
REQ-029 s_i=00000000000000000000000000000000, bypass=0 -> s_o=636363...63 (16 bytes), done_o exactly 5 edges after the start edge.
REQ-030 s_i=193de3bea0f4e22b9ac68d2ae9f84808, bypass=0 -> s_o=046681e5e0cb199a48f8d37a2806264c (FIPS-197 round 1).
REQ-031 Same s_i, bypass=1 -> s_o=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-032 s_i=00112233445566778899aabbccddeeff, bypass=1 -> s_o=63fcac161bee28c3c4c193f54b8233ea; feeding the output to inv_round_tf (bypass=1) returns the original s_i.
REQ-033 start_i pulsed again 2 cycles after an accepted start -> a single done_o only; the result matches the first s_i.
REQ-034 rst=1 for 1 cycle at the third SUB edge -> s_o=0, busy_o=0, no done_o; a following start completes normally.
